// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter for an asynchronous byte-wide SRAM.
// Each grant runs one fixed-length strobed access followed by a one-cycle turnaround.
module sram_arbiter #(
  parameter int pDATA_WIDTH  = 8,
  parameter int pADDR_WIDTH  = 21,
  parameter int pACCESS_CLKS = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   a_req,
  input  logic                   b_req,
  input  logic                   a_we,
  input  logic                   b_we,
  input  logic [pADDR_WIDTH-1:0] a_addr,
  input  logic [pADDR_WIDTH-1:0] b_addr,
  input  logic [pDATA_WIDTH-1:0] a_wdata,
  input  logic [pDATA_WIDTH-1:0] b_wdata,
  output logic                   a_ack,
  output logic                   b_ack,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic [1:0]             grant,
  output logic                   busy,
  output logic                   sram_cen,
  output logic                   sram_ce2,
  output logic                   sram_wen,
  output logic                   sram_oen,
  output logic [pADDR_WIDTH-1:0] sram_addr,
  inout  wire  [pDATA_WIDTH-1:0] sram_data
);

  localparam logic [3:0] CNT_LAST = 4'(pACCESS_CLKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_END    = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [3:0]             count_reg, count_next;
  logic                   last_b_reg, last_b_next;
  logic                   we_reg, we_next;
  logic [pDATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic                   drive_reg, drive_next;
  logic                   cen_reg, cen_next;
  logic                   ce2_reg, ce2_next;
  logic                   wen_reg, wen_next;
  logic                   oen_reg, oen_next;
  logic [pADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [1:0]             grant_reg, grant_next;
  logic                   ack_a_reg, ack_a_next;
  logic                   ack_b_reg, ack_b_next;
  logic [pDATA_WIDTH-1:0] rdata_reg, rdata_next;
  logic                   busy_reg, busy_next;

  logic start;
  logic pick_b;
  logic last_cnt;

  // B wins only when A is absent or A was served last.
  assign start    = (state_reg == ST_IDLE) && enable && (a_req || b_req);
  assign pick_b   = b_req && (!a_req || !last_b_reg);
  assign last_cnt = (count_reg == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (start) state_next = ST_ACCESS;
      ST_ACCESS: if (last_cnt) state_next = ST_END;
      ST_END:    state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    count_next  = count_reg;
    last_b_next = last_b_reg;
    we_next     = we_reg;
    wdata_next  = wdata_reg;
    drive_next  = drive_reg;
    cen_next    = cen_reg;
    ce2_next    = ce2_reg;
    wen_next    = wen_reg;
    oen_next    = oen_reg;
    addr_next   = addr_reg;
    grant_next  = grant_reg;
    ack_a_next  = 1'b0;
    ack_b_next  = 1'b0;
    rdata_next  = rdata_reg;
    busy_next   = busy_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          grant_next  = pick_b ? 2'b10 : 2'b01;
          last_b_next = pick_b;
          we_next     = pick_b ? b_we : a_we;
          addr_next   = pick_b ? b_addr : a_addr;
          wdata_next  = pick_b ? b_wdata : a_wdata;
          cen_next    = 1'b0;
          ce2_next    = 1'b1;
          wen_next    = pick_b ? !b_we : !a_we;
          oen_next    = pick_b ? b_we : a_we;
          count_next  = 4'd0;
          busy_next   = 1'b1;
        end
      end
      ST_ACCESS: begin
        count_next = count_reg + 4'd1;
        // Bus is turned on one clock after wen falls so the SRAM has stopped driving.
        if (we_reg) drive_next = 1'b1;
        if (last_cnt) begin
          if (!we_reg) rdata_next = sram_data;
          cen_next   = 1'b1;
          ce2_next   = 1'b0;
          wen_next   = 1'b1;
          oen_next   = 1'b1;
          ack_a_next = grant_reg[0];
          ack_b_next = grant_reg[1];
        end
      end
      ST_END: begin
        drive_next = 1'b0;
        grant_next = 2'b00;
        busy_next  = 1'b0;
      end
      default: begin
        drive_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg  <= 4'd0;
      last_b_reg <= 1'b1;
      we_reg     <= 1'b0;
      wdata_reg  <= '0;
      drive_reg  <= 1'b0;
      cen_reg    <= 1'b1;
      ce2_reg    <= 1'b0;
      wen_reg    <= 1'b1;
      oen_reg    <= 1'b1;
      addr_reg   <= '0;
      grant_reg  <= 2'b00;
      ack_a_reg  <= 1'b0;
      ack_b_reg  <= 1'b0;
      rdata_reg  <= '0;
      busy_reg   <= 1'b0;
    end else begin
      count_reg  <= count_next;
      last_b_reg <= last_b_next;
      we_reg     <= we_next;
      wdata_reg  <= wdata_next;
      drive_reg  <= drive_next;
      cen_reg    <= cen_next;
      ce2_reg    <= ce2_next;
      wen_reg    <= wen_next;
      oen_reg    <= oen_next;
      addr_reg   <= addr_next;
      grant_reg  <= grant_next;
      ack_a_reg  <= ack_a_next;
      ack_b_reg  <= ack_b_next;
      rdata_reg  <= rdata_next;
      busy_reg   <= busy_next;
    end
  end

  assign sram_data = drive_reg ? wdata_reg : {pDATA_WIDTH{1'bz}};
  assign sram_cen  = cen_reg;
  assign sram_ce2  = ce2_reg;
  assign sram_wen  = wen_reg;
  assign sram_oen  = oen_reg;
  assign sram_addr = addr_reg;
  assign grant     = grant_reg;
  assign a_ack     = ack_a_reg;
  assign b_ack     = ack_b_reg;
  assign rdata     = rdata_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small behavioural SRAM on the shared bus.
// Outputs are sampled 1 time unit after each rising edge; a released bus reads 0xFF.
module tb_sram_arbiter;

  localparam int P = 4;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        a_req, b_req;
  logic        a_we, b_we;
  logic [20:0] a_addr, b_addr;
  logic [7:0]  a_wdata, b_wdata;
  logic        a_ack, b_ack;
  logic [7:0]  rdata;
  logic [1:0]  grant;
  logic        busy;
  logic        sram_cen, sram_ce2, sram_wen, sram_oen;
  logic [20:0] sram_addr;
  tri1  [7:0]  sram_data;

  int tests = 0;
  int fails = 0;

  sram_arbiter #(
    .pDATA_WIDTH (8),
    .pADDR_WIDTH (21),
    .pACCESS_CLKS(P)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .a_req    (a_req),
    .b_req    (b_req),
    .a_we     (a_we),
    .b_we     (b_we),
    .a_addr   (a_addr),
    .b_addr   (b_addr),
    .a_wdata  (a_wdata),
    .b_wdata  (b_wdata),
    .a_ack    (a_ack),
    .b_ack    (b_ack),
    .rdata    (rdata),
    .grant    (grant),
    .busy     (busy),
    .sram_cen (sram_cen),
    .sram_ce2 (sram_ce2),
    .sram_wen (sram_wen),
    .sram_oen (sram_oen),
    .sram_addr(sram_addr),
    .sram_data(sram_data)
  );

  // Behavioural SRAM: a few address bits select among 32 bytes.
  logic [7:0] mem [32];
  wire  [4:0] mem_idx = {sram_addr[20], sram_addr[3:0]};
  wire  [7:0] rd_val  = mem[mem_idx];
  wire        rd_drive = !sram_cen && sram_ce2 && !sram_oen;
  assign sram_data = rd_drive ? rd_val : 8'bz;

  always @(posedge clk) begin
    if (!sram_cen && !sram_wen) mem[mem_idx] <= sram_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one access starting at the next (sampling) edge through the END edge.
  task automatic do_access(input string tag, input logic [1:0] g, input logic is_rd,
                           input logic [7:0] d, input logic [20:0] ad,
                           input int drop_at, input logic drop_en);
    tick();
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_strb0"}, 32'({sram_cen, sram_ce2, sram_wen, sram_oen}), 32'({1'b0, 1'b1, is_rd, !is_rd}));
    chk({tag, "_addr0"}, 32'(sram_addr), 32'(ad));
    chk({tag, "_busy0"}, 32'(busy), 32'(1));
    chk({tag, "_bus0"}, 32'(sram_data), 32'(is_rd ? d : 8'hFF));
    for (int e = 1; e < P; e++) begin
      tick();
      if (e == drop_at) begin
        if (drop_en) enable = 1'b0;
        else begin
          a_req = 1'b0;
          b_req = 1'b0;
        end
      end
      chk({tag, "_ack_mid"}, 32'({b_ack, a_ack}), 32'(0));
      chk({tag, "_cen_mid"}, 32'(sram_cen), 32'(0));
      chk({tag, "_addr_mid"}, 32'(sram_addr), 32'(ad));
      chk({tag, "_bus_mid"}, 32'(sram_data), 32'(d));
    end
    tick();
    chk({tag, "_ack"}, 32'({b_ack, a_ack}), 32'(g));
    chk({tag, "_strb_off"}, 32'({sram_cen, sram_ce2, sram_wen, sram_oen}), 32'(4'b1011));
    chk({tag, "_addr_end"}, 32'(sram_addr), 32'(ad));
    chk({tag, "_bus_end"}, 32'(sram_data), 32'(is_rd ? 8'hFF : d));
    if (is_rd) chk({tag, "_rdata"}, 32'(rdata), 32'(d));
    tick();
    chk({tag, "_ack_off"}, 32'({b_ack, a_ack}), 32'(0));
    chk({tag, "_grant_off"}, 32'(grant), 32'(0));
    chk({tag, "_busy_off"}, 32'(busy), 32'(0));
    chk({tag, "_bus_rel"}, 32'(sram_data), 32'(8'hFF));
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b1;
    a_req = 1'b0; b_req = 1'b0;
    a_we = 1'b0;  b_we = 1'b0;
    a_addr = '0;  b_addr = '0;
    a_wdata = '0; b_wdata = '0;
    tick();
    tick();
    chk("rst_strobes", 32'({sram_cen, sram_ce2, sram_wen, sram_oen}), 32'(4'b1011));
    chk("rst_addr", 32'(sram_addr), 32'(0));
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_ack", 32'({b_ack, a_ack}), 32'(0));
    chk("rst_rdata", 32'(rdata), 32'(0));
    chk("rst_bus", 32'(sram_data), 32'(8'hFF));
    reset_n = 1'b1;
    tick();

    // A writes 0xA5 then reads it back with req held through the ack
    a_req = 1'b1; a_we = 1'b1; a_addr = 21'h1F0000; a_wdata = 8'hA5;
    do_access("wr_a5", 2'b01, 1'b0, 8'hA5, 21'h1F0000, -1, 1'b0);
    a_we = 1'b0;
    do_access("rd_a5", 2'b01, 1'b1, 8'hA5, 21'h1F0000, -1, 1'b0);
    a_req = 1'b0;
    tick();
    chk("rdata_hold", 32'(rdata), 32'(8'hA5));
    chk("idle_grant", 32'(grant), 32'(0));

    // Simultaneous requests straight after reset alternate A,B,A,B
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 21'h000001; a_wdata = 8'h11;
    b_req = 1'b1; b_we = 1'b0; b_addr = 21'h1F0000;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) do_access("rr_a", 2'b01, 1'b0, 8'h11, 21'h000001, -1, 1'b0);
      else            do_access("rr_b", 2'b10, 1'b1, 8'hA5, 21'h1F0000, -1, 1'b0);
    end
    a_req = 1'b0; b_req = 1'b0;

    // A drops req at count 1 of a read
    a_req = 1'b1; a_we = 1'b0; a_addr = 21'h1F0000;
    do_access("drop", 2'b01, 1'b1, 8'hA5, 21'h1F0000, 1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("drop_no_regrant", 32'(grant), 32'(0));
      chk("drop_cen_idle", 32'(sram_cen), 32'(1));
    end

    // enable low holds off a pending B request
    enable = 1'b0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 21'h000000; b_wdata = 8'h00;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("en_off_grant", 32'(grant), 32'(0));
      chk("en_off_cen", 32'(sram_cen), 32'(1));
      chk("en_off_busy", 32'(busy), 32'(0));
    end
    enable = 1'b1;
    do_access("en_b", 2'b10, 1'b0, 8'h00, 21'h000000, 2, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("en_low_idle", 32'(grant), 32'(0));
    end
    b_req = 1'b0;
    enable = 1'b1;

    // Boundary addresses: 0x1FFFFF gets 0xFF, 0x000000 already holds 0x00
    b_req = 1'b1; b_we = 1'b1; b_addr = 21'h1FFFFF; b_wdata = 8'hFF;
    do_access("bnd_wff", 2'b10, 1'b0, 8'hFF, 21'h1FFFFF, -1, 1'b0);
    b_req = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 21'h000000;
    do_access("bnd_r00", 2'b01, 1'b1, 8'h00, 21'h000000, -1, 1'b0);
    a_addr = 21'h1FFFFF;
    do_access("bnd_rff", 2'b01, 1'b1, 8'hFF, 21'h1FFFFF, -1, 1'b0);
    a_req = 1'b0;
    tick();

    // Reset asserted at count 2 of a write
    a_req = 1'b1; a_we = 1'b1; a_addr = 21'h000002; a_wdata = 8'h3C;
    tick();
    tick();
    chk("mw_bus_driven", 32'(sram_data), 32'(8'h3C));
    tick();
    reset_n = 1'b0;
    #1;
    chk("mw_strobes", 32'({sram_cen, sram_ce2, sram_wen, sram_oen}), 32'(4'b1011));
    chk("mw_bus", 32'(sram_data), 32'(8'hFF));
    chk("mw_grant", 32'(grant), 32'(0));
    chk("mw_busy", 32'(busy), 32'(0));
    chk("mw_addr", 32'(sram_addr), 32'(0));
    tick();
    reset_n = 1'b1;
    do_access("post_rst", 2'b01, 1'b0, 8'h3C, 21'h000002, -1, 1'b0);
    a_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
